inst_fetch_queue: RTL

//  Decoupled instruction-fetch stage that replaces the direct PC->ROM path in front of the IF/ID register.

---
 rtl/inst_fetch_queue_pkg.sv | 21 ++
 rtl/inst_fetch_queue_fifo.sv | 62 ++++++
 rtl/inst_fetch_queue.sv | 93 +++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the decoupled instruction-fetch queue.
package inst_fetch_queue_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// DEPTH-entry {pc, inst} FIFO between the fetch FSM and decode, with a synchronous flush.
module inst_fetch_queue_fifo
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      count <= count + CNT_ONE;
         else if (do_pop && !do_push) count <= count - CNT_ONE;
      end
   end

   // NOTE: storage has no reset; count gates every read, so stale words are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
   pop_from_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupled fetch stage: one outstanding req/gnt/rvalid fetch, queued words to decode, redirect flush.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        id_ready
);

   fetch_state_e state;
   fetch_state_e next_state;
   logic [31:0]  fetch_pc;
   logic [31:0]  pc_out;
   logic         grant;
   logic         push;
   logic         pop;
   logic         fifo_full;
   logic         fifo_empty;
   fetch_entry_t head;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      next_state = state;
      imem_req   = 1'b0;
      grant      = 1'b0;
      push       = 1'b0;
      unique case (state)
         ST_REQ: begin
            imem_req = !fifo_full && !redirect_valid;
            grant    = imem_req && imem_gnt;
            if (grant) next_state = ST_WAIT;
         end
         ST_WAIT: begin
            // A redirect in the response cycle drops the word; without a response the fetch is orphaned.
            push = imem_rvalid && !redirect_valid;
            if (imem_rvalid)         next_state = ST_REQ;
            else if (redirect_valid) next_state = ST_DROP;
         end
         ST_DROP: begin
            if (imem_rvalid) next_state = ST_REQ;
         end
         default: next_state = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_REQ;
         fetch_pc <= RESET_PC;
         pc_out   <= '0;
      end else begin
         state <= next_state;
         if (redirect_valid) fetch_pc <= word_align(redirect_pc);
         else if (grant)     fetch_pc <= fetch_pc + 32'd4;
         if (grant) pc_out <= fetch_pc;
      end
   end

   assign pop = if_valid && id_ready && !redirect_valid;

   inst_fetch_queue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ('{pc: pc_out, inst: imem_rdata}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign imem_addr = fetch_pc;
   assign if_valid  = !fifo_empty;
   assign if_pc     = fifo_empty ? 32'h0 : head.pc;
   assign if_inst   = fifo_empty ? NOP_INST : head.inst;

endmodule
